// File: rtl/fractal_scheduler.sv
// Walks one frame in raster order, launches the Julia engine per pixel with an
// incrementally accumulated coordinate, and writes each iteration count to the bitmap.
module fractal_scheduler #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 32,
    parameter int ITER_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] y_max,
    input  logic [COORD_W-1:0] step,
    output logic               busy,
    output logic               frame_done,
    output logic               eng_start,
    output logic [COORD_W-1:0] eng_re,
    output logic [COORD_W-1:0] eng_im,
    input  logic               eng_done,
    input  logic [ITER_W-1:0]  eng_iter,
    output logic               bm_draw,
    output logic [9:0]         bm_x,
    output logic [9:0]         bm_y,
    output logic [ITER_W-1:0]  bm_i,
    input  logic               bm_ready
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [9:0] COL_LAST = 10'(H_RES - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_RES - 1);

    state_t             state_q, state_d;
    logic [9:0]         col_q, col_d;
    logic [9:0]         row_q, row_d;
    logic [COORD_W-1:0] re_q, re_d;
    logic [COORD_W-1:0] im_q, im_d;
    logic [COORD_W-1:0] x_min_q, x_min_d;
    logic [COORD_W-1:0] step_q, step_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               eng_start_q, eng_start_d;
    logic               bm_draw_q, bm_draw_d;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        re_d         = re_q;
        im_d         = im_q;
        x_min_d      = x_min_q;
        step_d       = step_q;
        iter_d       = iter_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        eng_start_d  = 1'b0;
        bm_draw_d    = bm_draw_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    x_min_d     = x_min;
                    step_d      = step;
                    col_d       = '0;
                    row_d       = '0;
                    re_d        = x_min;
                    im_d        = y_max;
                    busy_d      = 1'b1;
                    eng_start_d = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    iter_d    = eng_iter;
                    bm_draw_d = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bm_draw_q && bm_ready) begin
                    bm_draw_d = 1'b0;
                    if (col_q != COL_LAST) begin
                        col_d       = col_q + 10'd1;
                        re_d        = re_q + step_q;
                        eng_start_d = 1'b1;
                        state_d     = S_LAUNCH;
                    end else if (row_q != ROW_LAST) begin
                        // New row: real part restarts from the latched window edge.
                        col_d       = '0;
                        row_d       = row_q + 10'd1;
                        re_d        = x_min_q;
                        im_d        = im_q - step_q;
                        eng_start_d = 1'b1;
                        state_d     = S_LAUNCH;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            re_q         <= '0;
            im_q         <= '0;
            x_min_q      <= '0;
            step_q       <= '0;
            iter_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            eng_start_q  <= 1'b0;
            bm_draw_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            re_q         <= re_d;
            im_q         <= im_d;
            x_min_q      <= x_min_d;
            step_q       <= step_d;
            iter_q       <= iter_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            eng_start_q  <= eng_start_d;
            bm_draw_q    <= bm_draw_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign eng_start  = eng_start_q;
    assign eng_re     = re_q;
    assign eng_im     = im_q;
    assign bm_draw    = bm_draw_q;
    assign bm_x       = col_q;
    assign bm_y       = row_q;
    assign bm_i       = iter_q;

endmodule

// File: tb/tb_fractal_scheduler.sv
// Directed bench for fractal_scheduler on a 4x3 raster with a 2-cycle engine model.
module tb_fractal_scheduler;

    localparam int H = 4;
    localparam int V = 3;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [31:0] x_min, y_max, step;
    logic        busy, frame_done, eng_start;
    logic [31:0] eng_re, eng_im;
    logic        eng_done;
    logic [7:0]  eng_iter;
    logic        bm_draw;
    logic [9:0]  bm_x, bm_y;
    logic [7:0]  bm_i;
    logic        bm_ready;

    fractal_scheduler #(.H_RES(H), .V_RES(V), .COORD_W(32), .ITER_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .x_min(x_min), .y_max(y_max), .step(step),
        .busy(busy), .frame_done(frame_done), .eng_start(eng_start),
        .eng_re(eng_re), .eng_im(eng_im), .eng_done(eng_done), .eng_iter(eng_iter),
        .bm_draw(bm_draw), .bm_x(bm_x), .bm_y(bm_y), .bm_i(bm_i), .bm_ready(bm_ready)
    );

    always #5 clk = ~clk;

    // Engine model: done two cycles after start, iteration = launch index within frame.
    logic       d1, done_m, spur_done;
    logic [7:0] idx, iter_pipe, iter_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1 <= 1'b0; done_m <= 1'b0; idx <= '0; iter_pipe <= '0; iter_m <= '0;
        end else begin
            d1     <= eng_start;
            done_m <= d1;
            iter_m <= iter_pipe;
            if (eng_start) begin
                iter_pipe <= idx;
                idx       <= idx + 8'd1;
            end else if (!busy) begin
                idx <= '0;
            end
        end
    end
    assign eng_done = done_m | spur_done;
    assign eng_iter = done_m ? iter_m : 8'hEE;

    int n_writes = 0, n_done = 0, n_starts = 0;
    always @(posedge clk) begin
        if (bm_draw && bm_ready) n_writes <= n_writes + 1;
        if (frame_done)          n_done   <= n_done + 1;
        if (eng_start)           n_starts <= n_starts + 1;
    end

    typedef struct {
        logic [9:0]  col;
        logic [9:0]  row;
        logic [31:0] re;
        logic [31:0] im;
        logic [7:0]  it;
    } vec_t;
    vec_t tbl [NPIX];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                tbl[r*H+c].col = 10'(c);
                tbl[r*H+c].row = 10'(r);
                tbl[r*H+c].re  = xm + 32'(c) * st;
                tbl[r*H+c].im  = ym - 32'(r) * st;
                tbl[r*H+c].it  = 8'(c + H*r);
            end
    endtask

    task automatic wait_hi(input string name, input int which, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (((which == 0) ? eng_start : bm_draw) !== 1'b1) begin
            if (n == 30) begin
                checks++; failures++;
                $display("FAIL %s: timeout after %0d cycles", name, n);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Runs one frame against the table; optional stall, spurious-input and abort pixels.
    task automatic run_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st,
                             input int stall_idx, input int spur_idx, input int abort_idx);
        bit ok;
        int w0, d0;
        build(xm, ym, st);
        d0 = n_done;
        w0 = n_writes;
        @(negedge clk);
        x_min = xm; y_max = ym; step = st; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_eng_start", 64'(eng_start), 64'd1);
        for (int i = 0; i < NPIX; i++) begin
            wait_hi("wait_eng_start", 0, ok);
            if (!ok) return;
            chk($sformatf("eng_re[%0d]", i), 64'(eng_re), 64'(tbl[i].re));
            chk($sformatf("eng_im[%0d]", i), 64'(eng_im), 64'(tbl[i].im));
            if (i == spur_idx) begin
                spur_done = 1'b1; frame_start = 1'b1; x_min = 32'h5555_5555;
                @(negedge clk);
                spur_done = 1'b0; frame_start = 1'b0;
            end
            if (i == abort_idx) begin
                @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                chk("abort_coords", {eng_re, eng_im}, 64'd0);
                chk("abort_ctrl", 64'({busy, frame_done, eng_start, bm_draw, bm_x, bm_y, bm_i}), 64'd0);
                return;
            end
            if (i == stall_idx) bm_ready = 1'b0;
            wait_hi("wait_bm_draw", 1, ok);
            if (!ok) return;
            chk($sformatf("bm_x[%0d]", i), 64'(bm_x), 64'(tbl[i].col));
            chk($sformatf("bm_y[%0d]", i), 64'(bm_y), 64'(tbl[i].row));
            chk($sformatf("bm_i[%0d]", i), 64'(bm_i), 64'(tbl[i].it));
            chk($sformatf("hold_re[%0d]", i), 64'(eng_re), 64'(tbl[i].re));
            if (i == stall_idx) begin
                w0 = n_writes;
                for (int k = 0; k < 5; k++) begin
                    spur_done = (k == 1);
                    @(negedge clk);
                    spur_done = 1'b0;
                    chk("stall_bm", 64'({bm_draw, bm_x, bm_y, bm_i}),
                        64'({1'b1, tbl[i].col, tbl[i].row, tbl[i].it}));
                    chk("stall_no_start", 64'(eng_start), 64'd0);
                end
                chk("stall_no_write", 64'(n_writes - w0), 64'd0);
                bm_ready = 1'b1;
                @(negedge clk);
                chk("stall_one_write", 64'(n_writes - w0), 64'd1);
            end else begin
                @(negedge clk);
            end
            chk($sformatf("draw_drop[%0d]", i), 64'(bm_draw), 64'd0);
            if (i < NPIX - 1) begin
                chk($sformatf("relaunch[%0d]", i), 64'(eng_start), 64'd1);
            end else begin
                chk("frame_done_pulse", 64'({frame_done, busy}), 64'b11);
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
                chk("idle_after_done", 64'({frame_done, busy}), 64'b00);
                @(negedge clk);
                chk("start_in_done_ignored", 64'({eng_start, busy}), 64'b00);
            end
        end
        chk("frame_done_count", 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        reset_n = 1'b0; frame_start = 1'b0; spur_done = 1'b0; bm_ready = 1'b1;
        x_min = 32'h0; y_max = 32'h1000_0000; step = 32'h0100_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            frame_start = ~frame_start;
        end
        frame_start = 1'b0;
        @(negedge clk);
        chk("reset_coords", {eng_re, eng_im}, 64'd0);
        chk("reset_ctrl", 64'({busy, frame_done, eng_start, bm_draw, bm_x, bm_y, bm_i}), 64'd0);
        chk("reset_no_start", 64'(n_starts), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full frame, always ready.
        run_frame(32'h0, 32'h1000_0000, 32'h0100_0000, -1, -1, -1);
        chk("re_col3", 64'(tbl[3].re), 64'h0300_0000);
        chk("im_row2", 64'(tbl[8].im), 64'h0E00_0000);
        chk("writes_frame1", 64'(n_writes), 64'd12);

        // Backpressure on (2,1), spurious done in WRITE, spurious done/start in LAUNCH.
        run_frame(32'h0, 32'h1000_0000, 32'h0100_0000, 6, 3, -1);

        // Wrap-around without saturation.
        run_frame(32'h7F00_0000, 32'h0, 32'h0100_0000, -1, -1, -1);

        // Reset during WAIT at (1,1), then a clean restart.
        d0 = n_done;
        run_frame(32'h0, 32'h1000_0000, 32'h0100_0000, -1, -1, 5);
        s0 = n_starts;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_no_start", 64'(n_starts - s0), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run_frame(32'h0, 32'h1000_0000, 32'h0100_0000, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
